mipspipe_mp3: RTL and testbench

MIPSPIPE_MP3 -- requirements
Module: mipspipe_mp3

---
 rtl/mipspipe_mp3.sv | 218 +++++++++++++++++++++
 tb/tb_mipspipe_mp3.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mipspipe_mp3.sv
// Five-stage MIPS subset pipeline (LW, SW, BEQ, R-type ALU) with operand forwarding,
// a one-cycle load-use interlock and branches resolved in EX; state is observed hierarchically.
module mipspipe_mp3 #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input logic clock,
  input logic reset
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP = 32'h0000_0020;

  localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  // Architecturally visible state
  logic [31:0] PC, IFIDIR, IDEXA, IDEXB, EXMEMALUOut, EXMEMB, MEMWBValue;
  logic [4:0]  IDEXrs, IDEXrt, MEMWBrd, MEMWBrt;
  logic [5:0]  IDEXop, EXMEMop, MEMWBop;
  logic [31:0] Regs    [0:31];
  logic [31:0] IMemory [0:IMEM_WORDS-1];
  logic [31:0] DMemory [0:DMEM_WORDS-1];

  // Internal pipeline registers
  logic [4:0]  r_idex_rd, r_exmem_rd, r_exmem_rt;
  logic [5:0]  r_idex_funct;
  logic [31:0] r_idex_imm, r_idex_pc4;

  // Combinational signals
  logic [IAW-1:0] w_imem_idx;
  logic [DAW-1:0] w_dmem_idx;
  logic [5:0]     w_id_op, w_id_funct;
  logic [4:0]     w_id_rs, w_id_rt, w_id_rd;
  logic [31:0]    w_id_imm, w_id_a, w_id_b;
  logic           w_id_legal, w_id_uses_rt, w_stall;
  logic [4:0]     w_wb_dst;
  logic           w_exmem_fwd;
  logic [31:0]    w_fa, w_fb, w_alu, w_target, w_mem_value;
  logic           w_taken;

  // Word indices wrap modulo memory depth; byte-offset bits are dropped.
  assign w_imem_idx = IAW'({2'b00, PC[31:2]} % IMEM_WORDS);
  assign w_dmem_idx = DAW'({2'b00, EXMEMALUOut[31:2]} % DMEM_WORDS);

  // ---------------- ID decode ----------------
  assign w_id_op    = IFIDIR[31:26];
  assign w_id_rs    = IFIDIR[25:21];
  assign w_id_rt    = IFIDIR[20:16];
  assign w_id_rd    = IFIDIR[15:11];
  assign w_id_funct = IFIDIR[5:0];
  assign w_id_imm   = {{16{IFIDIR[15]}}, IFIDIR[15:0]};

  assign w_id_legal = (w_id_op inside {OP_LW, OP_SW, OP_BEQ}) ||
                      ((w_id_op == OP_R) &&
                       (w_id_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}));

  assign w_id_uses_rt = (w_id_op == OP_R) || (w_id_op == OP_SW) || (w_id_op == OP_BEQ);

  assign w_stall = (IDEXop == OP_LW) &&
                   ((w_id_rs == IDEXrt) || (w_id_uses_rt && (w_id_rt == IDEXrt)));

  // Destination register of the instruction in WB; zero means no write.
  always_comb begin
    w_wb_dst = 5'd0;
    if (MEMWBop == OP_R) begin
      w_wb_dst = MEMWBrd;
    end else if (MEMWBop == OP_LW) begin
      w_wb_dst = MEMWBrt;
    end
  end

  // Register read sees a same-cycle WB write.
  assign w_id_a = ((w_wb_dst != 5'd0) && (w_wb_dst == w_id_rs)) ? MEMWBValue : Regs[w_id_rs];
  assign w_id_b = ((w_wb_dst != 5'd0) && (w_wb_dst == w_id_rt)) ? MEMWBValue : Regs[w_id_rt];

  // ---------------- EX ----------------
  assign w_exmem_fwd = (EXMEMop == OP_R) && (r_exmem_rd != 5'd0);

  always_comb begin
    w_fa = IDEXA;
    if (w_exmem_fwd && (r_exmem_rd == IDEXrs)) begin
      w_fa = EXMEMALUOut;
    end else if ((w_wb_dst != 5'd0) && (w_wb_dst == IDEXrs)) begin
      w_fa = MEMWBValue;
    end
  end

  always_comb begin
    w_fb = IDEXB;
    if (w_exmem_fwd && (r_exmem_rd == IDEXrt)) begin
      w_fb = EXMEMALUOut;
    end else if ((w_wb_dst != 5'd0) && (w_wb_dst == IDEXrt)) begin
      w_fb = MEMWBValue;
    end
  end

  always_comb begin
    w_alu = 32'd0;
    case (IDEXop)
      OP_R: begin
        case (r_idex_funct)
          FN_ADD:  w_alu = w_fa + w_fb;
          FN_SUB:  w_alu = w_fa - w_fb;
          FN_AND:  w_alu = w_fa & w_fb;
          FN_OR:   w_alu = w_fa | w_fb;
          FN_SLT:  w_alu = {31'd0, ($signed(w_fa) < $signed(w_fb))};
          default: w_alu = 32'd0;
        endcase
      end
      OP_LW, OP_SW: w_alu = w_fa + r_idex_imm;
      default:      w_alu = 32'd0;
    endcase
  end

  assign w_taken  = (IDEXop == OP_BEQ) && (w_fa == w_fb);
  assign w_target = r_idex_pc4 + {r_idex_imm[29:0], 2'b00};

  // ---------------- MEM ----------------
  assign w_mem_value = (EXMEMop == OP_LW) ? DMemory[w_dmem_idx] : EXMEMALUOut;

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      PC           <= 32'd0;
      IFIDIR       <= NOP;
      IDEXop       <= OP_R;
      r_idex_funct <= FN_ADD;
      IDEXrs       <= 5'd0;
      IDEXrt       <= 5'd0;
      r_idex_rd    <= 5'd0;
      IDEXA        <= 32'd0;
      IDEXB        <= 32'd0;
      r_idex_imm   <= 32'd0;
      r_idex_pc4   <= 32'd0;
      EXMEMop      <= OP_R;
      EXMEMALUOut  <= 32'd0;
      EXMEMB       <= 32'd0;
      r_exmem_rd   <= 5'd0;
      r_exmem_rt   <= 5'd0;
      MEMWBop      <= OP_R;
      MEMWBValue   <= 32'd0;
      MEMWBrd      <= 5'd0;
      MEMWBrt      <= 5'd0;
    end else begin
      // A taken branch overrides a simultaneous load-use stall.
      if (w_taken) begin
        PC     <= w_target;
        IFIDIR <= NOP;
      end else if (!w_stall) begin
        PC     <= PC + 32'd4;
        IFIDIR <= IMemory[w_imem_idx];
      end

      // PC already points past the IF/ID instruction, so it is that instruction's PC+4.
      r_idex_pc4 <= PC;
      if (w_taken || w_stall || !w_id_legal) begin
        IDEXop       <= OP_R;
        r_idex_funct <= FN_ADD;
        IDEXrs       <= 5'd0;
        IDEXrt       <= 5'd0;
        r_idex_rd    <= 5'd0;
        IDEXA        <= 32'd0;
        IDEXB        <= 32'd0;
        r_idex_imm   <= 32'd0;
      end else begin
        IDEXop       <= w_id_op;
        r_idex_funct <= w_id_funct;
        IDEXrs       <= w_id_rs;
        IDEXrt       <= w_id_rt;
        r_idex_rd    <= w_id_rd;
        IDEXA        <= w_id_a;
        IDEXB        <= w_id_b;
        r_idex_imm   <= w_id_imm;
      end

      EXMEMop     <= IDEXop;
      EXMEMALUOut <= w_alu;
      EXMEMB      <= w_fb;
      r_exmem_rd  <= r_idex_rd;
      r_exmem_rt  <= IDEXrt;

      MEMWBop    <= EXMEMop;
      MEMWBValue <= w_mem_value;
      MEMWBrd    <= r_exmem_rd;
      MEMWBrt    <= r_exmem_rt;
    end
  end

  // ---------------- Register file ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        Regs[i] <= 32'(i);
      end
    end else if (w_wb_dst != 5'd0) begin
      Regs[w_wb_dst] <= MEMWBValue;
    end
  end

  // ---------------- Data memory ----------------
  always_ff @(posedge clock) begin
    if (!reset && (EXMEMop == OP_SW)) begin
      DMemory[w_dmem_idx] <= EXMEMB;
    end
  end

endmodule

// File: tb/tb_mipspipe_mp3.sv
// Bench for mipspipe_mp3: directed vector table, hand-written timing sequences and
// random programs checked against an instruction-level reference model.
module tb_mipspipe_mp3;

  localparam int unsigned IW = 1024;
  localparam int unsigned DW = 1024;
  localparam logic [31:0] NOP = 32'h0000_0020;

  logic clock;
  logic reset;

  mipspipe_mp3 #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clock(clock),
    .reset(reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] g_prog [0:63];
  logic [31:0] g_dmem [0:15];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_mem  [0:DW-1];

  typedef struct {
    logic [3:0][31:0] prog;
    int               len;
    int               cycles;
    bit               is_mem;
    int               idx;
    logic [31:0]      exp;
    logic [31:0]      d0;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Hold reset, load memories, take the reset edge, release reset 1 ns later.
  task automatic setup(input int n);
    reset = 1'b1;
    for (int i = 0; i < IW; i++) dut.IMemory[i] <= (i < n) ? g_prog[i] : NOP;
    for (int i = 0; i < DW; i++) dut.DMemory[i] <= (i < 16) ? g_dmem[i] : 32'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) g_prog[i] = NOP;
    for (int i = 0; i < 16; i++) g_dmem[i] = 32'd0;
  endtask

  // Instruction-at-a-time reference: no pipeline, just the architectural effect.
  task automatic model_run(input int n);
    int pc;
    logic [31:0] ir, a, b, addr, res;
    logic [5:0] op, fn;
    int rs, rt, rd, imm, idx;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    for (int i = 0; i < DW; i++) m_mem[i] = (i < 16) ? g_dmem[i] : 32'd0;
    pc = 0;
    while (pc < n) begin
      ir  = g_prog[pc];
      op  = ir[31:26];
      rs  = int'(ir[25:21]);
      rt  = int'(ir[20:16]);
      rd  = int'(ir[15:11]);
      fn  = ir[5:0];
      imm = int'($signed(ir[15:0]));
      a   = m_regs[rs];
      b   = m_regs[rt];
      addr = a + 32'(imm);
      idx = int'((addr / 4) % DW);
      pc++;
      if (op == 6'h00) begin
        res = 32'd0;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: rd = 0;
        endcase
        if (rd != 0) m_regs[rd] = res;
      end else if (op == 6'h23) begin
        if (rt != 0) m_regs[rt] = m_mem[idx];
      end else if (op == 6'h2B) begin
        m_mem[idx] = b;
      end else if (op == 6'h04) begin
        if (a == b) pc = pc + imm;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd;
    logic [5:0] fns [6];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h2A; fns[5] = 6'h21;
    k  = int'($urandom_range(0, 19));
    rs = int'($urandom_range(0, 7));
    rt = int'($urandom_range(0, 7));
    rd = int'($urandom_range(0, 7));
    if (k < 9)  return enc_r(rs, rt, rd, fns[(k < 8) ? (k % 5) : 5]);
    if (k < 13) return enc_i(6'h23, 0, rt, 4 * int'($urandom_range(0, 15)));
    if (k < 16) return enc_i(6'h2B, 0, rt, 4 * int'($urandom_range(0, 15)));
    if (k < 19) return enc_i(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt,
                             int'($urandom_range(0, 3)));
    return enc_i(6'h3F, rs, rt, int'($urandom_range(0, 65535)));
  endfunction

  initial begin
    logic [31:0] pcs [4];
    reset = 1'b1;

    // Directed vectors: program, cycles after reset, checked location, expected value.
    vecs[0] = '{prog: {NOP, NOP, NOP, 32'h00221820}, len: 1, cycles: 5,
                is_mem: 0, idx: 3, exp: 32'd3, d0: 32'd0};
    vecs[1] = '{prog: {NOP, NOP, 32'h00612022, 32'h00221820}, len: 2, cycles: 6,
                is_mem: 0, idx: 4, exp: 32'd2, d0: 32'd0};
    vecs[2] = '{prog: {NOP, NOP, 32'h00422020, 32'h8C020000}, len: 2, cycles: 7,
                is_mem: 0, idx: 4, exp: 32'h20, d0: 32'h10};
    vecs[3] = '{prog: {NOP, NOP, NOP, 32'hAC050008}, len: 1, cycles: 4,
                is_mem: 1, idx: 2, exp: 32'd5, d0: 32'd0};
    vecs[4] = '{prog: {32'h00213820, 32'h00213020, 32'h00213020, 32'h10000002}, len: 4,
                cycles: 8, is_mem: 0, idx: 7, exp: 32'd2, d0: 32'd0};
    vecs[5] = '{prog: {32'h00213820, 32'h00213020, 32'h00213020, 32'h10000002}, len: 4,
                cycles: 8, is_mem: 0, idx: 6, exp: 32'd6, d0: 32'd0};
    vecs[6] = '{prog: {NOP, 32'h00602020, 32'h00631820, 32'h00221820}, len: 3, cycles: 7,
                is_mem: 0, idx: 4, exp: 32'd6, d0: 32'd0};
    vecs[7] = '{prog: {NOP, NOP, 32'h0062202A, 32'h00011822}, len: 2, cycles: 6,
                is_mem: 0, idx: 4, exp: 32'd1, d0: 32'd0};
    vecs[8] = '{prog: {NOP, NOP, NOP, 32'h00220020}, len: 1, cycles: 6,
                is_mem: 0, idx: 0, exp: 32'd0, d0: 32'd0};

    // Reset state and free-running PC.
    clear_prog();
    setup(0);
    check("reset_pc", dut.PC, 32'd0);
    check("reset_ifidir", dut.IFIDIR, NOP);
    check("reset_regs7", dut.Regs[7], 32'd7);
    check("reset_idexop", {26'd0, dut.IDEXop}, 32'd0);
    check("reset_memwbvalue", dut.MEMWBValue, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("pc_step%0d", k), dut.PC, 32'(4 * k));
    end

    // Vector table.
    for (int v = 0; v < 9; v++) begin
      clear_prog();
      for (int i = 0; i < vecs[v].len; i++) g_prog[i] = vecs[v].prog[i];
      g_dmem[0] = vecs[v].d0;
      setup(vecs[v].len);
      repeat (vecs[v].cycles) @(posedge clock);
      #1;
      if (vecs[v].is_mem) check($sformatf("vec%0d_dmem", v), dut.DMemory[vecs[v].idx],
                                vecs[v].exp);
      else check($sformatf("vec%0d_reg", v), dut.Regs[vecs[v].idx], vecs[v].exp);
    end

    // Load-use: PC holds for exactly one cycle.
    clear_prog();
    g_prog[0] = 32'h8C020000;
    g_prog[1] = 32'h00422020;
    g_dmem[0] = 32'h10;
    setup(2);
    pcs[0] = 32'd4; pcs[1] = 32'd8; pcs[2] = 32'd8; pcs[3] = 32'd12;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("loaduse_pc%0d", k), dut.PC, pcs[k]);
    end

    // Taken branch: PC redirected from EX, reaching 16 after four edges.
    clear_prog();
    g_prog[0] = 32'h10000002;
    setup(4);
    pcs[0] = 32'd4; pcs[1] = 32'd8; pcs[2] = 32'd12; pcs[3] = 32'd16;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("branch_pc%0d", k), dut.PC, pcs[k]);
    end

    // Mid-program reset squashes an SW about to write.
    clear_prog();
    g_prog[0] = 32'hAC050008;
    g_dmem[2] = 32'h99;
    setup(1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset_dmem", dut.DMemory[2], 32'h99);
    check("midreset_pc", dut.PC, 32'd0);
    check("midreset_exmemop", {26'd0, dut.EXMEMop}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    check("midreset_rerun_dmem", dut.DMemory[2], 32'd5);

    // Random programs against the reference model.
    for (int t = 0; t < 8; t++) begin
      clear_prog();
      for (int i = 0; i < 24; i++) g_prog[i] = rand_instr();
      for (int i = 0; i < 16; i++) g_dmem[i] = $urandom;
      model_run(24);
      setup(24);
      repeat (2 * 24 + 12) @(posedge clock);
      #1;
      for (int r = 0; r < 8; r++)
        check($sformatf("rand%0d_reg%0d", t, r), dut.Regs[r], m_regs[r]);
      for (int m = 0; m < 16; m++)
        check($sformatf("rand%0d_dmem%0d", t, m), dut.DMemory[m], m_mem[m]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
